// File: rtl/gmii_cmd_pkg.sv
// Shared types and constants for the GMII control-channel command decoder.
// Offsets count bytes after the SFD.
package gmii_cmd_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_PRE,
      S_HDR,
      S_PAY,
      S_DROP
   } state_t;

   localparam logic [10:0] OFF_XSTART = 11'd15;
   localparam logic [10:0] OFF_XSTOP  = 11'd17;
   localparam logic [10:0] OFF_YSTART = 11'd19;
   localparam logic [10:0] OFF_YSTOP  = 11'd21;
   localparam logic [10:0] OFF_CMD    = 11'd23;

   localparam logic [7:0] CMD_START = 8'hFF;
   localparam logic [7:0] CMD_STOP  = 8'h00;
   localparam logic [7:0] PRE_BYTE  = 8'h55;
   localparam logic [7:0] SFD_BYTE  = 8'hD5;

   localparam logic [31:0] CRC_RESIDUE = 32'hC704DD7B;

   localparam logic [10:0] MIN_LEN_FCS   = 11'd64;
   localparam logic [10:0] MIN_LEN_NOFCS = 11'd24;

   function automatic logic [31:0] bitrev32(input logic [31:0] v);
      logic [31:0] r;
      for (int i = 0; i < 32; i++) r[i] = v[31-i];
      return r;
   endfunction

endpackage

// File: rtl/crc32_d8.sv
// Byte-wide IEEE 802.3 CRC-32, reflected (LSB first), init 0xFFFFFFFF.
// The register is not inverted; crc is the raw running remainder.
module crc32_d8 (
   input  logic        rx_clk,
   input  logic        reset,
   input  logic        init,
   input  logic        en,
   input  logic [7:0]  d,
   output logic [31:0] crc
);

   localparam logic [31:0] POLY_R = 32'hEDB88320;

   function automatic logic [31:0] step(input logic [31:0] c,
                                        input logic [7:0]  b);
      logic [31:0] r;
      r = c ^ {24'h0, b};
      for (int i = 0; i < 8; i++)
         r = r[0] ? ((r >> 1) ^ POLY_R) : (r >> 1);
      return r;
   endfunction

   always_ff @(posedge rx_clk or negedge reset) begin
      if (!reset)
         crc <= 32'hFFFF_FFFF;
      else if (init)
         crc <= 32'hFFFF_FFFF;
      else if (en)
         crc <= step(crc, d);
   end

endmodule

// File: rtl/gmii_cmd_rx.sv
// Parses host command frames on GMII RX and commits a capture window
// and capture-enable level once the whole frame has been validated.
module gmii_cmd_rx
   import gmii_cmd_pkg::*;
#(
   parameter logic [47:0] MAC_ADDR  = 48'h0EDA_0203_0405,
   parameter bit          CHECK_FCS = 1'b1,
   parameter int          MAX_LEN   = 1522
) (
   input  logic        rx_clk,
   input  logic        reset,
   input  logic [7:0]  gmii_rxd,
   input  logic        gmii_rx_dv,
   input  logic        gmii_rx_er,
   output logic [15:0] xstart,
   output logic [15:0] xstop,
   output logic [15:0] ystart,
   output logic [15:0] ystop,
   output logic        capture_en,
   output logic        cfg_valid,
   output logic        frame_err
);

   localparam logic [10:0] MIN_LEN = CHECK_FCS ? MIN_LEN_FCS : MIN_LEN_NOFCS;
   localparam logic [10:0] MAX_CNT = 11'(MAX_LEN);

   logic [7:0]  rxd_q;
   logic        dv_q;
   logic        er_q;

   state_t      state;
   logic [10:0] cnt;
   logic        uc_ok;
   logic        bc_ok;
   logic [15:0] xs_sh;
   logic [15:0] xe_sh;
   logic [15:0] ys_sh;
   logic [15:0] ye_sh;
   logic [7:0]  cmd_sh;
   logic        commit_p;
   logic        err_p;

   logic [31:0] crc;
   logic        crc_init;
   logic        crc_en;
   logic [7:0]  mac_byte;
   logic        uc_m;
   logic        bc_m;
   logic        ok_all;

   always_ff @(posedge rx_clk or negedge reset) begin
      if (!reset) begin
         rxd_q <= 8'h00;
         dv_q  <= 1'b0;
         er_q  <= 1'b0;
      end else begin
         rxd_q <= gmii_rxd;
         dv_q  <= gmii_rx_dv;
         er_q  <= gmii_rx_er;
      end
   end

   assign crc_init = (state == S_PRE) && dv_q && !er_q
                     && (rxd_q == SFD_BYTE);
   assign crc_en   = ((state == S_HDR) || (state == S_PAY)) && dv_q;

   crc32_d8 u_crc (
      .rx_clk (rx_clk),
      .reset  (reset),
      .init   (crc_init),
      .en     (crc_en),
      .d      (rxd_q),
      .crc    (crc)
   );

   always_comb begin
      mac_byte = MAC_ADDR[47:40];
      case (cnt[2:0])
         3'd1:    mac_byte = MAC_ADDR[39:32];
         3'd2:    mac_byte = MAC_ADDR[31:24];
         3'd3:    mac_byte = MAC_ADDR[23:16];
         3'd4:    mac_byte = MAC_ADDR[15:8];
         3'd5:    mac_byte = MAC_ADDR[7:0];
         default: ;
      endcase
   end

   assign uc_m = uc_ok && (rxd_q == mac_byte);
   assign bc_m = bc_ok && (rxd_q == 8'hFF);

   // Residue is compared in MSB-first bit order against the reflected register.
   assign ok_all = (cnt >= MIN_LEN)
                   && (!CHECK_FCS || (bitrev32(crc) == CRC_RESIDUE))
                   && ((cmd_sh == CMD_START) || (cmd_sh == CMD_STOP))
                   && (xs_sh <= xe_sh)
                   && (ys_sh <= ye_sh);

   always_ff @(posedge rx_clk or negedge reset) begin
      if (!reset) begin
         state    <= S_IDLE;
         cnt      <= 11'd0;
         uc_ok    <= 1'b0;
         bc_ok    <= 1'b0;
         xs_sh    <= 16'h0;
         xe_sh    <= 16'h0;
         ys_sh    <= 16'h0;
         ye_sh    <= 16'h0;
         cmd_sh   <= 8'h00;
         commit_p <= 1'b0;
         err_p    <= 1'b0;
      end else begin
         commit_p <= 1'b0;
         err_p    <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (dv_q)
                  state <= (!er_q && rxd_q == PRE_BYTE) ? S_PRE : S_DROP;
            end
            S_PRE: begin
               if (!dv_q)
                  state <= S_IDLE;
               else if (er_q)
                  state <= S_DROP;
               else if (rxd_q == SFD_BYTE) begin
                  state <= S_HDR;
                  cnt   <= 11'd0;
                  uc_ok <= 1'b1;
                  bc_ok <= 1'b1;
               end else if (rxd_q != PRE_BYTE)
                  state <= S_DROP;
            end
            S_HDR: begin
               if (!dv_q) begin
                  state <= S_IDLE;
                  err_p <= 1'b1;
               end else if (er_q) begin
                  state <= S_DROP;
                  err_p <= 1'b1;
               end else if (!uc_m && !bc_m) begin
                  // Frames for another station are filtered, not errors.
                  state <= S_DROP;
               end else begin
                  uc_ok <= uc_m;
                  bc_ok <= bc_m;
                  cnt   <= cnt + 11'd1;
                  if (cnt == 11'd5)
                     state <= S_PAY;
               end
            end
            S_PAY: begin
               if (!dv_q) begin
                  state    <= S_IDLE;
                  commit_p <= ok_all;
                  err_p    <= !ok_all;
               end else if (er_q || cnt == MAX_CNT) begin
                  state <= S_DROP;
                  err_p <= 1'b1;
               end else begin
                  cnt <= (cnt == 11'h7FF) ? cnt : cnt + 11'd1;
                  case (cnt)
                     OFF_XSTART:         xs_sh[15:8] <= rxd_q;
                     OFF_XSTART + 11'd1: xs_sh[7:0]  <= rxd_q;
                     OFF_XSTOP:          xe_sh[15:8] <= rxd_q;
                     OFF_XSTOP + 11'd1:  xe_sh[7:0]  <= rxd_q;
                     OFF_YSTART:         ys_sh[15:8] <= rxd_q;
                     OFF_YSTART + 11'd1: ys_sh[7:0]  <= rxd_q;
                     OFF_YSTOP:          ye_sh[15:8] <= rxd_q;
                     OFF_YSTOP + 11'd1:  ye_sh[7:0]  <= rxd_q;
                     OFF_CMD:            cmd_sh      <= rxd_q;
                     default: ;
                  endcase
               end
            end
            S_DROP: begin
               if (!dv_q)
                  state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge rx_clk or negedge reset) begin
      if (!reset) begin
         xstart     <= 16'h0;
         xstop      <= 16'h0;
         ystart     <= 16'h0;
         ystop      <= 16'h0;
         capture_en <= 1'b0;
         cfg_valid  <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         cfg_valid <= commit_p;
         frame_err <= err_p;
         if (commit_p) begin
            xstart     <= xs_sh;
            xstop      <= xe_sh;
            ystart     <= ys_sh;
            ystop      <= ye_sh;
            capture_en <= (cmd_sh == CMD_START);
         end
      end
   end

endmodule
